ripple_count_sequencer: RTL
===========================

# ripple_count_sequencer

Synchronous controller that sequences one asynchronous ripple up-counter through a measurement cycle: clear, count for a programmed gate window, wait for the ripple chain to settle, then capture a stable result. It sits between a register/command interface and the ripple counter. It owns the counter's active-low clear and the count-enable that gates the counter's input clock. It is the only safe way to read the counter from the synchronous domain.

## Interface
Parameters:
- N, 7, ripple counter width (bits of count_in and result)
- GATE_W, 16, width of the gate-window length
- SETTLE, 3, minimum idle cycles after gate close before sampling (≥1)
- CLR_CYC, 2, cycles the counter clear is held active (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin a measurement; sampled only in IDLE
- abort  input  1  synchronous abort; highest priority outside reset
- gate_len  input  GATE_W  gate window length in clk cycles, latched on accepted start
- count_in  input  N  ripple counter Q, asynchronous to clk
- cnt_clr_n  output  1  active-low clear to the counter's reset_n
- cnt_en  output  1  enable for the counter's input clock gate
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when result updates
- result  output  N  last captured count

## Operation
- Reset values: state IDLE, cnt_clr_n=1, cnt_en=0, busy=0, done=0, result=0. All outputs are registered.
- States: IDLE, CLEAR, RUN, SETTLE, CAPTURE.
- IDLE: on start=1, latch gate_len and go to CLEAR. gate_len=0 is latched as 1.
- CLEAR: cnt_clr_n=0 for exactly CLR_CYC cycles, then go to RUN.
- RUN: cnt_en=1 for exactly the latched gate_len cycles, then go to SETTLE.
- SETTLE:
  - cnt_en=0.
  - Wait SETTLE cycles.
  - Then register count_in every cycle into s0, and shift s0 into s1.
  - Go to CAPTURE once the wait has expired and s0==s1 with both loaded after the wait.
- CAPTURE: result<=s1, done=1 for one cycle, then go to IDLE.
- start while busy is ignored; it is not queued.
- abort in any non-IDLE state: next cycle returns to IDLE with cnt_en=0 and cnt_clr_n=1. result is unchanged and no done pulse is issued.
- abort and start together in IDLE: start is ignored.
- Asynchronous reset mid-operation forces the reset values immediately, including cnt_en=0.
- Counter wrap inside the window is not detected. result is the count mod 2^N.

## Timing
- start sampled at edge 0:
  - cnt_clr_n low for edges 1..CLR_CYC.
  - cnt_en high for the following gate_len cycles.
  - SETTLE wait, then at least 2 sample cycles, then CAPTURE.
- Minimum start-to-done latency is CLR_CYC + gate_len + SETTLE + 3 cycles. With defaults and gate_len=10, done asserts 18 cycles after start.
- result changes on the same edge that asserts done and is held until the next done.
- busy falls on the edge after done. A new start can be accepted on the cycle busy is low.

## Structure
- Package ripple_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, SETTLE, CAPTURE)
  - default constants for CLR_CYC and SETTLE
- One sub-module, count_sampler: the s0/s1 sample pair and equality compare. It has an enable input and a stable output.
- The FSM, the cycle counter (width max(GATE_W, $clog2(CLR_CYC+SETTLE+1))) and the result register live in the top module.

## Test plan
- Bench model: ripple counter clocked by clk gated by cnt_en, cleared by cnt_clr_n.
- gate_len=10, defaults: done pulses once 18 cycles after start; result=10; cnt_en high for exactly 10 cycles.
- gate_len=0: behaves as 1; result=1.
- N=7, gate_len=200: result=200 mod 128=72; no overflow indication.
- abort asserted 3 cycles into RUN: cnt_en low the next cycle; no done pulse; result keeps its previous value; busy falls.
- start held high through a whole measurement: exactly one measurement, then a second starts the cycle after busy falls.
- reset_n pulsed low during SETTLE: all outputs at reset values asynchronously; a following start with gate_len=5 yields result=5.

Source files
------------

// File: rtl/ripple_ctrl_pkg.sv
// Shared types and defaults for the ripple counter measurement sequencer.
package ripple_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_CAPTURE
  } state_e;

  localparam int DEF_CLR_CYC = 2;
  localparam int DEF_SETTLE  = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/count_sampler.sv
// Double-sample of the asynchronous ripple count; stable when two
// consecutive samples taken while enabled agree.
module count_sampler #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] s1_o,
  output logic         stable_o
);

  logic [N-1:0] s0_q, s1_q;
  logic [1:0]   vld_q;

  // Shift samples while enabled; drop validity as soon as enable goes away
  // so a fresh window always needs two new samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_q  <= '0;
      s1_q  <= '0;
      vld_q <= '0;
    end else if (en_i) begin
      s0_q  <= d_i;
      s1_q  <= s0_q;
      vld_q <= {vld_q[0], 1'b1};
    end else begin
      vld_q <= '0;
    end
  end

  assign s1_o     = s1_q;
  assign stable_o = vld_q[1] && (s0_q == s1_q);

endmodule

// File: rtl/ripple_count_sequencer.sv
// Sequences an asynchronous ripple counter through clear / gate / settle /
// capture and presents a stable registered result to the clk domain.
module ripple_count_sequencer
  import ripple_ctrl_pkg::*;
#(
  parameter int N       = 7,
  parameter int GATE_W  = 16,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int CLR_CYC = DEF_CLR_CYC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [N-1:0]      count_in,
  output logic              cnt_clr_n,
  output logic              cnt_en,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      result
);

  localparam int CW = max2(GATE_W, $clog2(CLR_CYC + SETTLE + 1));
  localparam logic [CW-1:0] ONE = CW'(1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [GATE_W-1:0] gate_q;
  logic              clr_n_q, en_q, busy_q, done_q;
  logic [N-1:0]      result_q;

  logic              samp_en;
  logic [N-1:0]      samp_s1;
  logic              samp_stable;

  // Sampling only starts once the settle wait has fully expired.
  assign samp_en = (state_q == S_SETTLE) && (cnt_q == '0);

  count_sampler #(.N(N)) u_sampler (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_i     (samp_en),
    .d_i      (count_in),
    .s1_o     (samp_s1),
    .stable_o (samp_stable)
  );

  // Measurement FSM; cnt_q is reused as the clear, gate and settle timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gate_q   <= GATE_W'(1);
      clr_n_q  <= 1'b1;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        en_q    <= 1'b0;
        clr_n_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              // A zero-length window would never open; treat it as one cycle.
              gate_q  <= (gate_len == '0) ? GATE_W'(1) : gate_len;
              cnt_q   <= CW'(CLR_CYC - 1);
              clr_n_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            if (cnt_q == '0) begin
              clr_n_q <= 1'b1;
              en_q    <= 1'b1;
              cnt_q   <= CW'(gate_q) - ONE;
              state_q <= S_RUN;
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          S_RUN: begin
            if (cnt_q == '0) begin
              en_q    <= 1'b0;
              cnt_q   <= CW'(SETTLE);
              state_q <= S_SETTLE;
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          S_SETTLE: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - ONE;
            end else if (samp_stable) begin
              result_q <= samp_s1;
              done_q   <= 1'b1;
              state_q  <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cnt_clr_n = clr_n_q;
  assign cnt_en    = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule
